// File: rtl/mult_share_arb.sv
// mult_share_arb: shares one 5-stage pipelined 18x18 unsigned multiplier among
// NREQ requesters, with round-robin arbitration, a requester tag on every
// product and a backpressurable response port.
//
// Build option: define MULT_SHARE_ARB_FIXED_PRIO_EN for fixed-priority
// arbitration (lowest index wins, no rotating pointer). Default: round-robin.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid[NREQ]          per-requester operand pair pending
//   req_a/req_b[NREQ*18]     operands, requester i at [18*i+17:18*i]
//   req_ready[NREQ]          one-hot grant (combinational)
//   rsp_valid/rsp_ready      response handshake
//   rsp_id[IDW], rsp_data[36] tag and product of the response
//   busy                     registered OR of pipeline stage valids
module mult_share_arb #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*18-1:0]   req_a,
    input  logic [NREQ*18-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [35:0]          rsp_data,
    output logic                 busy
);

    localparam int unsigned OPW  = 18;
    localparam int unsigned PW   = 36;
    localparam int unsigned NSTG = 5;
    localparam int unsigned CW   = IDW + 1;

    // Pipeline state: S0 holds operands, S1..S4 hold the product.
    logic [NSTG-1:0] stg_vld;
    logic [IDW-1:0]  stg_id   [NSTG];
    logic [OPW-1:0]  s0_a;
    logic [OPW-1:0]  s0_b;
    logic [PW-1:0]   stg_prod [1:NSTG-1];

    logic            advance_c;
    logic            accept_c;
    logic            found_c;
    logic [NREQ-1:0] grant_c;
    logic [IDW-1:0]  grant_id_c;
    logic [OPW-1:0]  sel_a_c;
    logic [OPW-1:0]  sel_b_c;

`ifndef MULT_SHARE_ARB_FIXED_PRIO_EN
    logic [IDW-1:0]  ptr;
    logic [CW-1:0]   scan_c;
    logic [CW-1:0]   ptr_nxt_c;
`endif

    // Whole pipeline freezes only when the output holds an unaccepted product.
    assign advance_c = !(stg_vld[NSTG-1] && !rsp_ready);

    // Winner selection.
    always_comb begin
        grant_c    = '0;
        grant_id_c = '0;
        found_c    = 1'b0;
`ifdef MULT_SHARE_ARB_FIXED_PRIO_EN
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found_c && req_valid[i]) begin
                grant_c[i] = 1'b1;
                grant_id_c = IDW'(i);
                found_c    = 1'b1;
            end
        end
`else
        scan_c = '0;
        // Scan upward from ptr, wrapping NREQ-1 -> 0 (NREQ need not be a power of 2).
        for (int unsigned off = 0; off < NREQ; off++) begin
            scan_c = {1'b0, ptr} + CW'(off);
            if (scan_c >= CW'(NREQ)) begin
                scan_c = scan_c - CW'(NREQ);
            end
            if (!found_c && req_valid[scan_c[IDW-1:0]]) begin
                grant_c[scan_c[IDW-1:0]] = 1'b1;
                grant_id_c = scan_c[IDW-1:0];
                found_c    = 1'b1;
            end
        end
`endif
    end

    // Grant is suppressed during reset and while the pipeline is stalled.
    assign req_ready = (rst || !advance_c) ? '0 : grant_c;
    assign accept_c  = |req_ready;

    // Operand mux for the granted requester.
    always_comb begin
        sel_a_c = '0;
        sel_b_c = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_c[i]) begin
                sel_a_c = req_a[OPW*i +: OPW];
                sel_b_c = req_b[OPW*i +: OPW];
            end
        end
    end

`ifndef MULT_SHARE_ARB_FIXED_PRIO_EN
    // Pointer moves to the slot after the winner.
    always_comb begin
        ptr_nxt_c = {1'b0, grant_id_c} + CW'(1);
        if (ptr_nxt_c == CW'(NREQ)) begin
            ptr_nxt_c = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (accept_c) begin
            ptr <= ptr_nxt_c[IDW-1:0];
        end
    end
`endif

    // Pipeline shift; bubbles travel along with valid entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_vld <= '0;
            s0_a    <= '0;
            s0_b    <= '0;
            for (int unsigned i = 0; i < NSTG; i++) begin
                stg_id[i] <= '0;
            end
            for (int unsigned i = 1; i < NSTG; i++) begin
                stg_prod[i] <= '0;
            end
        end else if (advance_c) begin
            stg_vld <= {stg_vld[NSTG-2:0], accept_c};
            if (accept_c) begin
                s0_a      <= sel_a_c;
                s0_b      <= sel_b_c;
                stg_id[0] <= grant_id_c;
            end
            for (int unsigned i = 1; i < NSTG; i++) begin
                stg_id[i] <= stg_id[i-1];
            end
            stg_prod[1] <= PW'(s0_a) * PW'(s0_b);
            for (int unsigned i = 2; i < NSTG; i++) begin
                stg_prod[i] <= stg_prod[i-1];
            end
        end
    end

    // busy lags the stage valids by one register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
        end else begin
            busy <= |stg_vld;
        end
    end

    assign rsp_valid = stg_vld[NSTG-1];
    assign rsp_id    = stg_id[NSTG-1];
    assign rsp_data  = stg_prod[NSTG-1];

endmodule

// File: tb/tb_mult_share_arb.sv
// Self-checking bench for mult_share_arb: directed scenarios plus randomized
// traffic, checked against a queue-based reference of in-flight products.
module tb_mult_share_arb;

    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = 2;
    localparam int unsigned OPW  = 18;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*OPW-1:0]  req_a;
    logic [NREQ*OPW-1:0]  req_b;
    logic [NREQ-1:0]      req_ready;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [35:0]          rsp_data;
    logic                 busy;

    always #5 clk = ~clk;

    mult_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: every accepted product with the count of advancing edges since acceptance.
    typedef struct {
        int unsigned     id;
        longint unsigned prod;
        int unsigned     age;
    } ent_t;

    ent_t            q[$];
    int unsigned     m_ptr;
    bit              m_busy;
    bit              r_valid [NREQ];
    logic [OPW-1:0]  r_a     [NREQ];
    logic [OPW-1:0]  r_b     [NREQ];
    int              last_grant;
    int              grant_log[$];
    int unsigned     obs_id[$];
    longint unsigned obs_data[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]           = r_valid[i];
            req_a[OPW*i +: OPW]    = r_a[i];
            req_b[OPW*i +: OPW]    = r_b[i];
        end
    endtask

    function automatic int model_grant(input bit adv);
        if (!adv) return -1;
        for (int unsigned k = 0; k < NREQ; k++) begin
            int idx;
`ifdef MULT_SHARE_ARB_FIXED_PRIO_EN
            idx = int'(k);
`else
            idx = int'((m_ptr + k) % NREQ);
`endif
            if (r_valid[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [OPW-1:0] pick_op();
        case ($urandom_range(0, 9))
            0:       return '0;
            1:       return '1;
            default: return OPW'($urandom);
        endcase
    endfunction

    // One clock: check at negedge, update reference at posedge, return at posedge+1.
    task automatic run_cycle();
        bit              ev;
        bit              adv;
        int              g;
        logic [NREQ-1:0] exp_rdy;
        bit              busy_n;
        ent_t            e;
        @(negedge clk);
        ev  = (q.size() > 0) && (q[0].age == 4);
        adv = !(ev && !rsp_ready);
        g   = model_grant(adv);
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(exp_rdy));
        check("rsp_valid", 64'(rsp_valid), 64'(ev));
        if (ev) begin
            check("rsp_id", 64'(rsp_id), 64'(q[0].id));
            check("rsp_data", 64'(rsp_data), q[0].prod);
        end
        check("busy", 64'(busy), 64'(m_busy));
        if (rsp_valid && rsp_ready) begin
            obs_id.push_back(32'(rsp_id));
            obs_data.push_back(64'(rsp_data));
        end
        if (g >= 0) grant_log.push_back(g);
        last_grant = g;
        @(posedge clk);
        busy_n = (q.size() > 0);
        if (adv) begin
            if (ev) void'(q.pop_front());
            foreach (q[j]) q[j].age++;
            if (g >= 0) begin
                e.id   = 32'(g);
                e.prod = 64'(r_a[g]) * 64'(r_b[g]);
                e.age  = 0;
                q.push_back(e);
                m_ptr = (32'(g) + 1) % NREQ;
            end
        end
        m_busy = busy_n;
        #1;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_data", 64'(rsp_data), 64'd0);
        check("rst_rsp_id", 64'(rsp_id), 64'd0);
        q.delete();
        m_ptr  = 0;
        m_busy = 1'b0;
        for (int i = 0; i < NREQ; i++) r_valid[i] = 1'b0;
        drive();
        @(negedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        grant_log.delete();
        obs_id.delete();
        obs_data.delete();
    endtask

    initial begin
        int k;
        rst       = 1'b1;
        rsp_ready = 1'b1;
        m_ptr     = 0;
        m_busy    = 1'b0;
        last_grant = -1;
        for (int i = 0; i < NREQ; i++) begin
            r_valid[i] = 1'b0;
            r_a[i]     = '0;
            r_b[i]     = '0;
        end
        drive();
        @(posedge clk);
        #1;
        do_reset();
        run_cycle();

        // Single request from requester 2.
        clear_logs();
        r_valid[2] = 1'b1; r_a[2] = 18'd3; r_b[2] = 18'd5;
        drive();
        run_cycle();
        r_valid[2] = 1'b0;
        drive();
        repeat (7) run_cycle();
        check("single_count", 64'(obs_id.size()), 64'd1);
        if (obs_id.size() > 0) begin
            check("single_id", 64'(obs_id[0]), 64'd2);
            check("single_data", obs_data[0], 64'd15);
        end
        check("single_busy_low", 64'(busy), 64'd0);

        // Maximum operands.
        clear_logs();
        r_valid[1] = 1'b1; r_a[1] = 18'h3FFFF; r_b[1] = 18'h3FFFF;
        drive();
        run_cycle();
        r_valid[1] = 1'b0;
        drive();
        repeat (7) run_cycle();
        check("max_count", 64'(obs_id.size()), 64'd1);
        if (obs_data.size() > 0) check("max_data", obs_data[0], 64'h0000_000F_FFF8_0001);

`ifndef MULT_SHARE_ARB_FIXED_PRIO_EN
        // Round-robin fairness from a freshly reset pointer.
        do_reset();
        clear_logs();
        for (int i = 0; i < NREQ; i++) begin
            r_valid[i] = 1'b1; r_a[i] = OPW'(i + 1); r_b[i] = 18'd10;
        end
        drive();
        repeat (8) run_cycle();
        for (int i = 0; i < NREQ; i++) r_valid[i] = 1'b0;
        drive();
        repeat (8) run_cycle();
        check("rr_grants", 64'(grant_log.size()), 64'd8);
        for (int j = 0; j < grant_log.size() && j < 8; j++)
            check("rr_grant_seq", 64'(grant_log[j]), 64'(j % 4));
        check("rr_rsp_count", 64'(obs_id.size()), 64'd8);
        for (int j = 0; j < obs_id.size() && j < 8; j++) begin
            check("rr_rsp_id", 64'(obs_id[j]), 64'(j % 4));
            check("rr_rsp_data", obs_data[j], 64'((j % 4 + 1) * 10));
        end
`endif

        // Backpressure: six products, rsp_ready low for three cycles mid-stream.
        clear_logs();
        k = 0;
        for (int c = 0; c < 24; c++) begin
            r_valid[0] = (k < 6);
            r_a[0]     = OPW'(k + 1);
            r_b[0]     = 18'd7;
            rsp_ready  = !(c >= 5 && c < 8);
            drive();
            run_cycle();
            if (last_grant == 0) k++;
        end
        rsp_ready = 1'b1;
        check("bp_count", 64'(obs_id.size()), 64'd6);
        for (int j = 0; j < obs_data.size() && j < 6; j++)
            check("bp_order", obs_data[j], 64'((j + 1) * 7));

        // Reset with products in flight.
        clear_logs();
        for (int j = 0; j < 3; j++) begin
            r_valid[1] = 1'b1; r_a[1] = OPW'(j + 2); r_b[1] = 18'd9;
            drive();
            run_cycle();
        end
        for (int i = 0; i < NREQ; i++) r_valid[i] = 1'b1;
        drive();
        do_reset();
        repeat (8) run_cycle();
        check("midrst_no_rsp", 64'(obs_id.size()), 64'd0);
        grant_log.delete();
        for (int i = 0; i < NREQ; i++) begin
            r_valid[i] = 1'b1; r_a[i] = OPW'(i); r_b[i] = 18'd4;
        end
        drive();
        run_cycle();
        check("midrst_grant_cnt", 64'(grant_log.size()), 64'd1);
        if (grant_log.size() > 0) check("midrst_first_grant", 64'(grant_log[0]), 64'd0);
        for (int i = 0; i < NREQ; i++) r_valid[i] = 1'b0;
        drive();
        repeat (8) run_cycle();

`ifdef MULT_SHARE_ARB_FIXED_PRIO_EN
        // Fixed priority: requester 1 always beats requester 3.
        clear_logs();
        r_valid[1] = 1'b1; r_a[1] = 18'd11; r_b[1] = 18'd2;
        r_valid[3] = 1'b1; r_a[3] = 18'd13; r_b[3] = 18'd2;
        drive();
        repeat (6) run_cycle();
        r_valid[1] = 1'b0;
        drive();
        repeat (2) run_cycle();
        r_valid[3] = 1'b0;
        drive();
        repeat (8) run_cycle();
        check("fp_grants", 64'(grant_log.size()), 64'd8);
        for (int j = 0; j < grant_log.size() && j < 8; j++)
            check("fp_grant_seq", 64'(grant_log[j]), (j < 6) ? 64'd1 : 64'd3);
`endif

        // Randomized traffic with random backpressure.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (r_valid[i] && last_grant == i) begin
                    r_valid[i] = ($urandom_range(0, 9) < 6);
                    r_a[i] = pick_op();
                    r_b[i] = pick_op();
                end else if (!r_valid[i]) begin
                    if ($urandom_range(0, 9) < 4) begin
                        r_valid[i] = 1'b1;
                        r_a[i] = pick_op();
                        r_b[i] = pick_op();
                    end
                end else if ($urandom_range(0, 9) == 0) begin
                    r_valid[i] = 1'b0;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            drive();
            run_cycle();
        end

        // Drain.
        for (int i = 0; i < NREQ; i++) r_valid[i] = 1'b0;
        rsp_ready = 1'b1;
        drive();
        repeat (10) run_cycle();
        check("final_busy", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
